bbox_scan_ctrl: RTL and testbench
=================================

Name: bbox_scan_ctrl

Overview:
Controller that sequences a full raster read of the second camera frame buffer (320x240, RGB444) through its read port after a photo completes. It classifies each pixel against a colour threshold and accumulates the bounding box (x_min/x_max/y_min/y_max) of matching pixels. It exchanges a start/started/done/ack handshake with the top-level main state machine in the MIN_MAX states. It runs in the 25 MHz VGA/camera domain.

Parameters:
FRAME_W, 320, pixels per line
FRAME_H, 240, lines per frame
RD_LAT, 1, frame-buffer read latency in clocks (address to data), 1..3
R_MIN, 4'd10, red channel must be >= this
G_MAX, 4'd5, green channel must be <= this
B_MAX, 4'd5, blue channel must be <= this

Ports:
clk  in  1  25 MHz clock; frame-buffer read port clock
rst  in  1  synchronous reset, active-high
start  in  1  level request from main FSM; sampled only in IDLE
ack  in  1  acknowledge of done; sampled only in DONE
started  out  1  one-cycle pulse when a scan is accepted
busy  out  1  high in SCAN and FLUSH
done  out  1  high throughout DONE
rd_addr  out  17  frame-buffer read address (y*FRAME_W + x)
rd_data  in  12  pixel {R[11:8],G[7:4],B[3:0]}, valid RD_LAT clocks after rd_addr
found  out  1  at least one pixel matched in the last scan
x_min, x_max  out  9  bounding-box columns
y_min, y_max  out  9  bounding-box rows

Behaviour:
- Clocking: single clock clk; reset is synchronous and active-high (rst).
- Reset values: state=IDLE, rd_addr=0, started=0, busy=0, done=0, found=0, x_min=x_max=y_min=y_max=0.
- States: IDLE, SCAN, FLUSH, DONE.
  - IDLE: if start=1 at edge N -> SCAN. On the same edge: started=1 for one cycle, rd_addr=0, x/y counters=0, and the working accumulators are cleared (wmin_x=wmin_y=9'h1FF, wmax_x=wmax_y=0, wfound=0). Published outputs hold their previous values until DONE.
  - SCAN: rd_addr increments by 1 each clock; x counter wraps at FRAME_W-1 and increments y. When rd_addr=FRAME_W*FRAME_H-1 (76799) has been presented for one cycle -> FLUSH. rd_addr holds at 76799.
  - FLUSH: lasts RD_LAT+1 clocks to drain the pipeline, then -> DONE.
  - DONE: on entry, publish the accumulators. found=wfound. If wfound=0, all four coordinates=0; otherwise min/max are driven from the accumulators. done=1 until ack=1 is sampled, then -> IDLE (done=0 on that edge).
- Pipeline: the (x,y,valid) tag is delayed RD_LAT stages to align with rd_data. Match = (R>=R_MIN)&&(G<=G_MAX)&&(B<=B_MAX). On a valid match: wmin/wmax update with unsigned compare; wfound=1.
- Latency: done rises at edge N+FRAME_W*FRAME_H+RD_LAT+1, which is 76802 clocks for RD_LAT=1.
- Outputs: published coordinates are stable from DONE entry until the next DONE entry.
- Edge cases:
  - start held high while in SCAN/FLUSH/DONE: ignored.
  - start still high when returning to IDLE: a new scan begins on the next edge.
  - ack outside DONE: ignored.
  - ack high on the DONE entry edge: done stays high for one cycle minimum.
  - rst at any point, including mid-scan: immediate return to reset values; no partial result is published.
- Bounds: x <= 319 and y <= 239 always; addresses never exceed 76799.

Decomposition:
- Shared header bbox_const.vh holds: FRAME_W/FRAME_H, address width 17, coordinate width 9, pixel width 12, and state encodings BB_IDLE=0, BB_SCAN=1, BB_FLUSH=2, BB_DONE=3. The main FSM shares the same image geometry.
- One sub-module, bbox_pixel_match: combinational threshold classifier, parameterised by R_MIN/G_MAX/B_MAX. It is reused later by the filter path.

Test Plan:
- Single match: frame all 12'h000 except addr 6410 = 12'hF00 (x=10,y=20); pulse start -> started pulse; done at +76802 clocks; found=1, x_min=x_max=10, y_min=y_max=20.
- Rectangle: matches at (5,7), (300,7), (5,200), (300,200) plus interior 12'hF00 -> x_min=5, x_max=300, y_min=7, y_max=200; pixel 12'hF60 (G=6) at (0,0) rejected.
- Boundaries, RD_LAT=2 build: matches only at addr 0 and 76799 -> x_min=0, x_max=319, y_min=0, y_max=239; done at +76803 clocks.
- Empty frame: no matches -> found=0, all coordinates 0; done held high 50 clocks with ack=0, then ack=1 -> done=0 and IDLE next edge.
- Mid-scan reset: rst=1 at addr 30000 -> next edge busy=0, rd_addr=0, outputs 0. A new start then yields the correct box from test 1.
- Handshake: start held high through DONE and ack -> exactly one started pulse per scan, with back-to-back scans. ack pulses during SCAN -> no effect.

Source files
------------

// File: rtl/bbox_scan_ctrl_pkg.sv
// Shared geometry, widths and state encoding for the bounding-box scan path.
// The main FSM imports the same image geometry from here.
package bbox_scan_ctrl_pkg;

  localparam int BB_FRAME_W = 320;
  localparam int BB_FRAME_H = 240;
  localparam int ADDR_W     = 17;
  localparam int COORD_W    = 9;
  localparam int PIX_W      = 12;

  typedef enum logic [1:0] {
    BB_IDLE  = 2'd0,
    BB_SCAN  = 2'd1,
    BB_FLUSH = 2'd2,
    BB_DONE  = 2'd3
  } bbState_e;

  // Pixel coordinate travelling alongside its read request.
  typedef struct packed {
    logic               valid;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pixTag_t;

endpackage

// File: rtl/bbox_pixel_match.sv
// Combinational RGB444 colour-threshold classifier; shared with the filter path.
module bbox_pixel_match
  import bbox_scan_ctrl_pkg::*;
#(
  parameter logic [3:0] R_MIN = 4'd10,
  parameter logic [3:0] G_MAX = 4'd5,
  parameter logic [3:0] B_MAX = 4'd5
) (
  input  logic [PIX_W-1:0] pixel_i,
  output logic             match_o
);

  assign match_o = (pixel_i[11:8] >= R_MIN) &&
                   (pixel_i[7:4]  <= G_MAX) &&
                   (pixel_i[3:0]  <= B_MAX);

endmodule

// File: rtl/bbox_scan_ctrl.sv
// Raster-scans the frame buffer after a photo, classifies each pixel and
// publishes the bounding box of matching pixels via a start/done/ack handshake.
module bbox_scan_ctrl
  import bbox_scan_ctrl_pkg::*;
#(
  parameter int         FRAME_W = BB_FRAME_W,
  parameter int         FRAME_H = BB_FRAME_H,
  parameter int         RD_LAT  = 1,
  parameter logic [3:0] R_MIN   = 4'd10,
  parameter logic [3:0] G_MAX   = 4'd5,
  parameter logic [3:0] B_MAX   = 4'd5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               ack,
  output logic               started,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [PIX_W-1:0]   rd_data,
  output logic               found,
  output logic [COORD_W-1:0] x_min,
  output logic [COORD_W-1:0] x_max,
  output logic [COORD_W-1:0] y_min,
  output logic [COORD_W-1:0] y_max
);

  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(FRAME_W * FRAME_H - 1);
  localparam logic [COORD_W-1:0] LAST_X    = COORD_W'(FRAME_W - 1);

  bbState_e           state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COORD_W-1:0] xCnt_q, xCnt_d, yCnt_q, yCnt_d;
  logic [1:0]         flushCnt_q, flushCnt_d;
  logic               started_q, started_d;
  logic [COORD_W-1:0] wMinX_q, wMinX_d, wMaxX_q, wMaxX_d;
  logic [COORD_W-1:0] wMinY_q, wMinY_d, wMaxY_q, wMaxY_d;
  logic               wFound_q, wFound_d;
  logic               found_q, found_d;
  logic [COORD_W-1:0] xMin_q, xMin_d, xMax_q, xMax_d;
  logic [COORD_W-1:0] yMin_q, yMin_d, yMax_q, yMax_d;

  pixTag_t tagPipe_q [RD_LAT];
  pixTag_t tagIn;
  pixTag_t tagOut;
  logic    pixMatch;

  bbox_pixel_match #(
    .R_MIN(R_MIN),
    .G_MAX(G_MAX),
    .B_MAX(B_MAX)
  ) uMatch (
    .pixel_i(rd_data),
    .match_o(pixMatch)
  );

  // The tag is delayed by the frame-buffer latency so it lines up with rd_data.
  assign tagIn  = '{valid: (state_q == BB_SCAN), x: xCnt_q, y: yCnt_q};
  assign tagOut = tagPipe_q[RD_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) tagPipe_q[i] <= '0;
    end else begin
      tagPipe_q[0] <= tagIn;
      for (int i = 1; i < RD_LAT; i++) tagPipe_q[i] <= tagPipe_q[i-1];
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    xCnt_d     = xCnt_q;
    yCnt_d     = yCnt_q;
    flushCnt_d = flushCnt_q;
    started_d  = 1'b0;
    wMinX_d    = wMinX_q;
    wMaxX_d    = wMaxX_q;
    wMinY_d    = wMinY_q;
    wMaxY_d    = wMaxY_q;
    wFound_d   = wFound_q;
    found_d    = found_q;
    xMin_d     = xMin_q;
    xMax_d     = xMax_q;
    yMin_d     = yMin_q;
    yMax_d     = yMax_q;

    if (tagOut.valid && pixMatch) begin
      wFound_d = 1'b1;
      if (tagOut.x < wMinX_q) wMinX_d = tagOut.x;
      if (tagOut.x > wMaxX_q) wMaxX_d = tagOut.x;
      if (tagOut.y < wMinY_q) wMinY_d = tagOut.y;
      if (tagOut.y > wMaxY_q) wMaxY_d = tagOut.y;
    end

    case (state_q)
      BB_IDLE: begin
        if (start) begin
          state_d   = BB_SCAN;
          started_d = 1'b1;
          addr_d    = '0;
          xCnt_d    = '0;
          yCnt_d    = '0;
          wMinX_d   = '1;
          wMinY_d   = '1;
          wMaxX_d   = '0;
          wMaxY_d   = '0;
          wFound_d  = 1'b0;
        end
      end
      BB_SCAN: begin
        if (addr_q == LAST_ADDR) begin
          state_d    = BB_FLUSH;
          flushCnt_d = '0;
        end else begin
          addr_d = addr_q + 17'd1;
          if (xCnt_q == LAST_X) begin
            xCnt_d = '0;
            yCnt_d = yCnt_q + 9'd1;
          end else begin
            xCnt_d = xCnt_q + 9'd1;
          end
        end
      end
      BB_FLUSH: begin
        if (flushCnt_q == 2'(RD_LAT)) begin
          state_d = BB_DONE;
          found_d = wFound_q;
          xMin_d  = wFound_q ? wMinX_q : '0;
          xMax_d  = wFound_q ? wMaxX_q : '0;
          yMin_d  = wFound_q ? wMinY_q : '0;
          yMax_d  = wFound_q ? wMaxY_q : '0;
        end else begin
          flushCnt_d = flushCnt_q + 2'd1;
        end
      end
      BB_DONE: begin
        if (ack) state_d = BB_IDLE;
      end
      default: state_d = BB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BB_IDLE;
      addr_q     <= '0;
      xCnt_q     <= '0;
      yCnt_q     <= '0;
      flushCnt_q <= '0;
      started_q  <= 1'b0;
      wMinX_q    <= '1;
      wMinY_q    <= '1;
      wMaxX_q    <= '0;
      wMaxY_q    <= '0;
      wFound_q   <= 1'b0;
      found_q    <= 1'b0;
      xMin_q     <= '0;
      xMax_q     <= '0;
      yMin_q     <= '0;
      yMax_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      xCnt_q     <= xCnt_d;
      yCnt_q     <= yCnt_d;
      flushCnt_q <= flushCnt_d;
      started_q  <= started_d;
      wMinX_q    <= wMinX_d;
      wMinY_q    <= wMinY_d;
      wMaxX_q    <= wMaxX_d;
      wMaxY_q    <= wMaxY_d;
      wFound_q   <= wFound_d;
      found_q    <= found_d;
      xMin_q     <= xMin_d;
      xMax_q     <= xMax_d;
      yMin_q     <= yMin_d;
      yMax_q     <= yMax_d;
    end
  end

  assign started = started_q;
  assign busy    = (state_q == BB_SCAN) || (state_q == BB_FLUSH);
  assign done    = (state_q == BB_DONE);
  assign rd_addr = addr_q;
  assign found   = found_q;
  assign x_min   = xMin_q;
  assign x_max   = xMax_q;
  assign y_min   = yMin_q;
  assign y_max   = yMax_q;

endmodule

// File: tb/tb_bbox_scan_ctrl.sv
// Scoreboard bench for bbox_scan_ctrl on a reduced 40x30 frame, with one
// instance at read latency 1 and one at read latency 2.
`timescale 1ns/1ps
module tb_bbox_scan_ctrl;
  import bbox_scan_ctrl_pkg::*;

  localparam int TW   = 40;
  localparam int TH   = 30;
  localparam int TPIX = TW * TH;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic rst = 1'b1;
  logic start1 = 1'b0, ack1 = 1'b0, start2 = 1'b0, ack2 = 1'b0;
  logic started1, busy1, done1, found1, started2, busy2, done2, found2;
  logic [ADDR_W-1:0]  rdAddr1, rdAddr2;
  logic [PIX_W-1:0]   rdData1, rdData2, lat2Stage;
  logic [COORD_W-1:0] xMin1, xMax1, yMin1, yMax1, xMin2, xMax2, yMin2, yMax2;

  logic [11:0] frame [TPIX];

  bbox_scan_ctrl #(.FRAME_W(TW), .FRAME_H(TH), .RD_LAT(1)) uDut1 (
    .clk(clk), .rst(rst), .start(start1), .ack(ack1), .started(started1),
    .busy(busy1), .done(done1), .rd_addr(rdAddr1), .rd_data(rdData1),
    .found(found1), .x_min(xMin1), .x_max(xMax1), .y_min(yMin1), .y_max(yMax1)
  );

  bbox_scan_ctrl #(.FRAME_W(TW), .FRAME_H(TH), .RD_LAT(2)) uDut2 (
    .clk(clk), .rst(rst), .start(start2), .ack(ack2), .started(started2),
    .busy(busy2), .done(done2), .rd_addr(rdAddr2), .rd_data(rdData2),
    .found(found2), .x_min(xMin2), .x_max(xMax2), .y_min(yMin2), .y_max(yMax2)
  );

  // Frame-buffer models: one and two registered read stages.
  always @(posedge clk) begin
    rdData1   <= (int'(rdAddr1) < TPIX) ? frame[rdAddr1] : 12'h000;
    lat2Stage <= (int'(rdAddr2) < TPIX) ? frame[rdAddr2] : 12'h000;
    rdData2   <= lat2Stage;
  end

  typedef struct {
    int found;
    int xMin;
    int xMax;
    int yMin;
    int yMax;
    int latency;
  } expRes_t;

  expRes_t sbQ[$];
  int errCount   = 0;
  int checkCount = 0;
  int prevFound [2] = '{0, 0};
  int prevXMax  [2] = '{0, 0};

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic expRes_t modelBox(input int lat);
    expRes_t r;
    logic [11:0] p;
    r = '{found: 0, xMin: 0, xMax: 0, yMin: 0, yMax: 0, latency: TPIX + lat + 1};
    for (int y = 0; y < TH; y++) begin
      for (int x = 0; x < TW; x++) begin
        p = frame[y*TW + x];
        if (p[11:8] >= 4'd10 && p[7:4] <= 4'd5 && p[3:0] <= 4'd5) begin
          if (r.found == 0) begin
            r.xMin = x; r.xMax = x; r.yMin = y; r.yMax = y;
          end else begin
            if (x < r.xMin) r.xMin = x;
            if (x > r.xMax) r.xMax = x;
            if (y < r.yMin) r.yMin = y;
            if (y > r.yMax) r.yMax = y;
          end
          r.found = 1;
        end
      end
    end
    return r;
  endfunction

  function automatic int selDone(input int inst);
    return (inst == 0) ? int'(done1) : int'(done2);
  endfunction
  function automatic int selBusy(input int inst);
    return (inst == 0) ? int'(busy1) : int'(busy2);
  endfunction
  function automatic int selStarted(input int inst);
    return (inst == 0) ? int'(started1) : int'(started2);
  endfunction
  function automatic int selFound(input int inst);
    return (inst == 0) ? int'(found1) : int'(found2);
  endfunction

  task automatic setStart(input int inst, input logic v);
    if (inst == 0) start1 = v; else start2 = v;
  endtask
  task automatic setAck(input int inst, input logic v);
    if (inst == 0) ack1 = v; else ack2 = v;
  endtask

  function automatic void clearFrame();
    for (int i = 0; i < TPIX; i++) frame[i] = 12'h000;
  endfunction

  function automatic void loadSingle();
    clearFrame();
    frame[20*TW + 10] = 12'hF00;
  endfunction

  // One full scan: push the expected box, run to done, pop and compare, then ack.
  task automatic applyStimulus(input int inst, input bit holdStart, input bit ackDuringScan,
                               input int holdDone, input string name);
    expRes_t e, got;
    int edges, pulses, doneCnt, seen;
    int obsXMin, obsXMax, obsYMin, obsYMax;
    e = modelBox(inst == 1 ? 2 : 1);
    sbQ.push_back(e);
    setStart(inst, 1'b1);
    edges = 0; pulses = 0; seen = 0;
    while (edges < e.latency + 50) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (!holdStart) setStart(inst, 1'b0);
      if (ackDuringScan) setAck(inst, (edges >= 100 && edges < 104));
      if (edges == 1) checkOutput({name, " busy after start"}, selBusy(inst), 1);
      if (selStarted(inst) == 1) pulses++;
      if (edges == 50) begin
        checkOutput({name, " held found"}, selFound(inst), prevFound[inst]);
        checkOutput({name, " held x_max"}, (inst == 0) ? int'(xMax1) : int'(xMax2), prevXMax[inst]);
      end
      if (selDone(inst) == 1) begin
        seen = 1;
        break;
      end
    end
    setAck(inst, 1'b0);
    checkOutput({name, " done seen"}, seen, 1);
    checkOutput({name, " done latency"}, edges - 1, e.latency);
    got = sbQ.pop_front();
    obsXMin = (inst == 0) ? int'(xMin1) : int'(xMin2);
    obsXMax = (inst == 0) ? int'(xMax1) : int'(xMax2);
    obsYMin = (inst == 0) ? int'(yMin1) : int'(yMin2);
    obsYMax = (inst == 0) ? int'(yMax1) : int'(yMax2);
    checkOutput({name, " found"}, selFound(inst), got.found);
    checkOutput({name, " x_min"}, obsXMin, got.xMin);
    checkOutput({name, " x_max"}, obsXMax, got.xMax);
    checkOutput({name, " y_min"}, obsYMin, got.yMin);
    checkOutput({name, " y_max"}, obsYMax, got.yMax);
    prevFound[inst] = got.found;
    prevXMax[inst]  = got.xMax;
    doneCnt = 0;
    repeat (holdDone) begin
      @(posedge clk);
      @(negedge clk);
      if (selDone(inst) == 1) doneCnt++;
      if (selStarted(inst) == 1) pulses++;
    end
    checkOutput({name, " done held"}, doneCnt, holdDone);
    checkOutput({name, " started pulses"}, pulses, 1);
    setAck(inst, 1'b1);
    @(posedge clk);
    @(negedge clk);
    setAck(inst, 1'b0);
    checkOutput({name, " done after ack"}, selDone(inst), 0);
    checkOutput({name, " busy after ack"}, selBusy(inst), 0);
  endtask

  initial begin
    #(40 * 100000);
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waitCnt;
    clearFrame();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", int'(busy1), 0);
    checkOutput("reset done", int'(done1), 0);
    checkOutput("reset started", int'(started1), 0);
    checkOutput("reset found", int'(found1), 0);
    checkOutput("reset rd_addr", int'(rdAddr1), 0);
    checkOutput("reset x_min", int'(xMin1), 0);
    checkOutput("reset y_max", int'(yMax1), 0);
    rst = 1'b0;

    $display("[TB] single match");
    loadSingle();
    applyStimulus(0, 1'b0, 1'b0, 2, "single");

    $display("[TB] rectangle with ack pulses during scan");
    clearFrame();
    frame[7*TW + 5]   = 12'hF00;
    frame[7*TW + 30]  = 12'hF00;
    frame[25*TW + 5]  = 12'hF00;
    frame[25*TW + 30] = 12'hF00;
    frame[10*TW + 10] = 12'hF00;
    frame[12*TW + 15] = 12'hA55;
    frame[0]          = 12'hF60;
    frame[29*TW + 39] = 12'h900;
    frame[29*TW + 0]  = 12'hF06;
    applyStimulus(0, 1'b0, 1'b1, 0, "rect");

    $display("[TB] mid-scan reset");
    loadSingle();
    start1 = 1'b1;
    waitCnt = 0;
    while (int'(rdAddr1) != 600 && waitCnt < 2000) begin
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
      waitCnt++;
    end
    checkOutput("midreset reached addr", int'(rdAddr1), 600);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset busy", int'(busy1), 0);
    checkOutput("midreset rd_addr", int'(rdAddr1), 0);
    checkOutput("midreset found", int'(found1), 0);
    checkOutput("midreset x_max", int'(xMax1), 0);
    checkOutput("midreset y_max", int'(yMax1), 0);
    checkOutput("midreset done", int'(done1), 0);
    prevFound[0] = 0; prevXMax[0] = 0;
    prevFound[1] = 0; prevXMax[1] = 0;
    applyStimulus(0, 1'b0, 1'b0, 1, "after reset");

    $display("[TB] empty frame with long done hold");
    clearFrame();
    applyStimulus(0, 1'b0, 1'b0, 50, "empty");

    $display("[TB] back-to-back scans with start held");
    loadSingle();
    applyStimulus(0, 1'b1, 1'b1, 5, "b2b first");
    applyStimulus(0, 1'b1, 1'b0, 5, "b2b second");
    start1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("b2b idle busy", int'(busy1), 0);
    checkOutput("b2b idle started", int'(started1), 0);

    $display("[TB] read latency 2 boundary pixels");
    clearFrame();
    frame[0]        = 12'hF00;
    frame[TPIX - 1] = 12'hF00;
    applyStimulus(1, 1'b0, 1'b0, 2, "lat2");

    $display("[TB] Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
